// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths, reset PC default and the NOP encoding.
// Imported by every pipeline stage so the widths stay consistent across the design.
package mips_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0]   RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP          = 32'h0000_0000;

    typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic inter-stage pipeline register: clears on reset or squash, holds on stall, loads otherwise.
// Written for IF/ID but kept stage-agnostic so later stages can reuse it.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int PCL    = PC_W,
    parameter int INST_W = mips_pkg::INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              squash,
    input  logic [INST_W-1:0] inst_p0,
    input  logic [PCL-1:0]    pc4_p0,
    input  logic              vld_p0,
    output logic [INST_W-1:0] inst_p1,
    output logic [PCL-1:0]    pc4_p1,
    output logic              vld_p1
);

    // ---- stage boundary p0 -> p1 ----
    // Squash beats stall: a wrong-path word must not survive a hazard hold.
    always_ff @(posedge clk) begin
        if (rst || squash) begin
            inst_p1 <= INST_W'(NOP);
            pc4_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (!stall) begin
            inst_p1 <= inst_p0;
            pc4_p1  <= pc4_p0;
            vld_p1  <= vld_p0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, IF/ID capture,
// sticky misaligned-redirect flag and a count of instructions accepted into IF/ID.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int            PCL      = PC_W,
    parameter logic [PCL-1:0] RESET_PC = PCL'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [PCL-1:0]    redirect_pc,
    output logic [PCL-1:0]    imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] ifid_inst,
    output logic [PCL-1:0]    ifid_pc4,
    output logic              ifid_valid,
    output logic              misalign,
    output logic [31:0]       fetch_count
);

    logic [PCL-1:0] pc_p0;
    logic [PCL-1:0] pc4_p0;
    logic [PCL-1:0] pc_nxt;
    logic           squash;
    logic           load;

    // Targets are forced onto a word boundary; the low bits only feed the misalign flag.
    function automatic logic [PCL-1:0] align_word(input logic [PCL-1:0] a);
        return {a[PCL-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [PCL-1:0] a);
        return |a[1:0];
    endfunction

    // Natural modulo-2^PCL wrap; no overflow indication is wanted.
    assign pc4_p0 = pc_p0 + PCL'(4);

    // A redirect also squashes: the word currently in IF is on the wrong path.
    assign squash = flush | redirect_valid;
    assign load   = ~squash & ~stall;

    always_comb begin
        pc_nxt = pc4_p0;
        if (redirect_valid)
            pc_nxt = align_word(redirect_pc);
        else if (stall)
            pc_nxt = pc_p0;
    end

    // ---- stage boundary: PC register (p0) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0       <= RESET_PC;
            misalign    <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc_p0 <= pc_nxt;
            if (redirect_valid && is_misaligned(redirect_pc))
                misalign <= 1'b1;
            if (load)
                fetch_count <= fetch_count + 32'd1;
        end
    end

    assign imem_addr = pc_p0;

    if_id_reg #(
        .PCL    (PCL),
        .INST_W (INST_W)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .squash  (squash),
        .inst_p0 (imem_data),
        .pc4_p0  (pc4_p0),
        .vld_p0  (1'b1),
        .inst_p1 (ifid_inst),
        .pc4_p1  (ifid_pc4),
        .vld_p1  (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle scoreboard against a reference model,
// plus directed checks for stall, redirect, misalign, flush, mid-stream reset and PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    logic        w_rst;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [31:0] w_inst;
    logic [31:0] w_pc4;
    logic        w_valid;
    logic        w_mis;
    logic [31:0] w_cnt;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        v;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
    logic        m_v, m_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    assign imem_data = mem_word(imem_addr);
    assign w_data    = mem_word(w_addr);

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .ifid_inst      (ifid_inst),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid),
        .misalign       (misalign),
        .fetch_count    (fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk            (clk),
        .rst            (w_rst),
        .stall          (1'b0),
        .flush          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_addr      (w_addr),
        .imem_data      (w_data),
        .ifid_inst      (w_inst),
        .ifid_pc4       (w_pc4),
        .ifid_valid     (w_valid),
        .misalign       (w_mis),
        .fetch_count    (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the reference model, then compare after the edge.
    task automatic step(input logic r, input logic s, input logic f, input logic rv,
                        input logic [31:0] rpc);
        exp_t e;
        rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
        if (r) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_v = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else begin
            if (f || rv) begin
                m_inst = 32'h0; m_pc4 = 32'h0; m_v = 1'b0;
            end else if (!s) begin
                m_inst = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_v = 1'b1; m_cnt = m_cnt + 32'd1;
            end
            if (rv && (rpc[1:0] != 2'b00)) m_mis = 1'b1;
            if (rv)      m_pc = {rpc[31:2], 2'b00};
            else if (!s) m_pc = m_pc + 32'd4;
        end
        e = '{pc: m_pc, inst: m_inst, pc4: m_pc4, v: m_v, mis: m_mis, cnt: m_cnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("sb_addr",  imem_addr,           e.pc);
            check("sb_inst",  ifid_inst,           e.inst);
            check("sb_pc4",   ifid_pc4,            e.pc4);
            check("sb_valid", {31'b0, ifid_valid}, {31'b0, e.v});
            check("sb_mis",   {31'b0, misalign},   {31'b0, e.mis});
            check("sb_cnt",   fetch_count,         e.cnt);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        w_rst = 1'b1;

        // Reset state
        step(1, 0, 0, 0, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_inst",  ifid_inst, 32'h0);
        check("rst_pc4",   ifid_pc4, 32'h0);
        check("rst_valid", {31'b0, ifid_valid}, 32'h0);
        check("rst_cnt",   fetch_count, 32'h0);

        // Free run from 0: first edge after reset loads the word at 0
        step(0, 0, 0, 0, 32'h0);
        check("run0_inst", ifid_inst, mem_word(32'h0));
        check("run0_pc4",  ifid_pc4, 32'h4);
        check("run0_addr", imem_addr, 32'h4);
        step(0, 0, 0, 0, 32'h0);
        check("run1_pc4",  ifid_pc4, 32'h8);
        check("run1_addr", imem_addr, 32'h8);

        // Stall for 3 cycles while PC=8
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, 32'h0);
            check("stall_addr", imem_addr, 32'h8);
            check("stall_pc4",  ifid_pc4, 32'h8);
            check("stall_cnt",  fetch_count, 32'h2);
        end
        step(0, 0, 0, 0, 32'h0);
        check("rel_pc4",  ifid_pc4, 32'hC);
        check("rel_inst", ifid_inst, mem_word(32'h8));
        step(0, 0, 0, 0, 32'h0);
        check("four_cnt",  fetch_count, 32'h4);
        check("four_pc4",  ifid_pc4, 32'h10);
        check("four_addr", imem_addr, 32'h10);

        // Redirect to 0x40 at PC=0x10 with stall also high
        step(0, 1, 0, 1, 32'h40);
        check("rd_addr",  imem_addr, 32'h40);
        check("rd_valid", {31'b0, ifid_valid}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("rd_inst",  ifid_inst, mem_word(32'h40));
        check("rd_pc4",   ifid_pc4, 32'h44);
        check("rd_valid2", {31'b0, ifid_valid}, 32'h1);

        // Misaligned redirect to 0x42
        step(0, 0, 0, 1, 32'h42);
        check("mis_addr", imem_addr, 32'h40);
        check("mis_flag", {31'b0, misalign}, 32'h1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 32'h0);
        check("mis_sticky", {31'b0, misalign}, 32'h1);

        // Flush alone: IF/ID squashed while PC advances
        step(0, 0, 1, 0, 32'h0);
        check("fl_valid", {31'b0, ifid_valid}, 32'h0);
        check("fl_inst",  ifid_inst, 32'h0);
        check("fl_addr",  imem_addr, 32'h50);

        // Flush together with stall: PC holds, IF/ID squashed
        step(0, 0, 0, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        check("fs_addr",  imem_addr, 32'h54);
        check("fs_valid", {31'b0, ifid_valid}, 32'h0);

        // Random mix, checked by the scoreboard
        for (int k = 0; k < 60; k++) begin
            logic s, f, rv;
            logic [31:0] t;
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 7) == 0);
            rv = ($urandom_range(0, 7) == 0);
            t  = {16'h0, 8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            step(0, s, f, rv, t);
        end

        // Mid-stream reset with a redirect and stall pending
        step(0, 0, 0, 1, 32'h203);
        step(1, 1, 0, 1, 32'h300);
        check("mrst_addr",  imem_addr, 32'h0);
        check("mrst_inst",  ifid_inst, 32'h0);
        check("mrst_pc4",   ifid_pc4, 32'h0);
        check("mrst_valid", {31'b0, ifid_valid}, 32'h0);
        check("mrst_mis",   {31'b0, misalign}, 32'h0);
        check("mrst_cnt",   fetch_count, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("post_cnt", fetch_count, 32'h1);

        // PC wrap with RESET_PC=0xFFFFFFF8
        w_rst = 1'b1;
        @(posedge clk); #1;
        check("w_rst_addr", w_addr, 32'hFFFF_FFF8);
        check("w_rst_valid", {31'b0, w_valid}, 32'h0);
        w_rst = 1'b0;
        @(posedge clk); #1;
        check("w_addr1", w_addr, 32'hFFFF_FFFC);
        check("w_pc4_1", w_pc4, 32'hFFFF_FFFC);
        check("w_inst1", w_inst, mem_word(32'hFFFF_FFF8));
        @(posedge clk); #1;
        check("w_addr2", w_addr, 32'h0);
        check("w_pc4_2", w_pc4, 32'h0);
        check("w_inst2", w_inst, mem_word(32'hFFFF_FFFC));
        check("w_mis",   {31'b0, w_mis}, 32'h0);
        @(posedge clk); #1;
        check("w_pc4_3", w_pc4, 32'h4);
        check("w_cnt",   w_cnt, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
